// File: rtl/regfile_cmd_pkg.sv
// Shared types and constants for the UART-driven register-file command controller.
// Optional read watchdog is enabled with the RD_TIMEOUT_EN macro.
package regfile_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

  localparam int          OP_WIDTH_D = 8;
  localparam int          ADDR_D     = 4;
  localparam logic [7:0]  WR_CMD_D   = 8'hAA;
  localparam logic [7:0]  RD_CMD_D   = 8'hBB;
  localparam int          RD_TIMEOUT = 16;

endpackage

// File: rtl/rd_watchdog.sv
// Read-response watchdog: counts cycles while run is high.
// Only instantiated when RD_TIMEOUT_EN is defined.
module rd_watchdog
  import regfile_cmd_pkg::*;
#(
  parameter int LIMIT = RD_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(LIMIT);

  logic [W-1:0] cnt;

  // Held at zero outside the wait so every wait starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + W'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign expired = run && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/regfile_cmd_ctrl.sv
// Decodes UART RX frames into register-file writes/reads and returns read data to TX.
// Define RD_TIMEOUT_EN to abort reads that get no response within 16 cycles.
module regfile_cmd_ctrl
  import regfile_cmd_pkg::*;
#(
  parameter int                  OP_WIDTH = OP_WIDTH_D,
  parameter int                  ADDR     = ADDR_D,
  parameter logic [OP_WIDTH-1:0] WR_CMD   = WR_CMD_D,
  parameter logic [OP_WIDTH-1:0] RD_CMD   = RD_CMD_D
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [OP_WIDTH-1:0] RX_P_DATA,
  input  logic                RX_D_VLD,
  input  logic [OP_WIDTH-1:0] RdData,
  input  logic                RdData_VLD,
  input  logic                TX_Busy,
  output logic                WrEn,
  output logic                RdEn,
  output logic [ADDR-1:0]     Address,
  output logic [OP_WIDTH-1:0] WrData,
  output logic [OP_WIDTH-1:0] TX_P_DATA,
  output logic                TX_D_VLD,
  output logic                CMD_ERR
);

  state_t state;
  state_t state_nx;

  logic                rd_tmo;
  logic                tmo_hit;
  logic                wr_en_nx;
  logic                rd_en_nx;
  logic [ADDR-1:0]     addr_nx;
  logic [OP_WIDTH-1:0] wdata_nx;
  logic [OP_WIDTH-1:0] txd_nx;
  logic                tx_vld_nx;
  logic                err_nx;

`ifdef RD_TIMEOUT_EN
  rd_watchdog #(
    .LIMIT (RD_TIMEOUT)
  ) u_wdog (
    .clk     (CLK),
    .rst     (RST),
    .run     (state == RD_WAIT),
    .expired (rd_tmo)
  );
`else
  assign rd_tmo = 1'b0;
`endif

  // A response arriving on the expiry cycle still wins.
  assign tmo_hit = rd_tmo && !RdData_VLD;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD) begin
            state_nx = WR_ADDR;
          end else if (RX_P_DATA == RD_CMD) begin
            state_nx = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) state_nx = WR_DATA;
      end
      WR_DATA: begin
        if (RX_D_VLD) state_nx = IDLE;
      end
      RD_ADDR: begin
        if (RX_D_VLD) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (tmo_hit) begin
          state_nx = IDLE;
        end else if (RdData_VLD) begin
          // Idle TX takes the byte at once; otherwise park in TX_SEND.
          state_nx = TX_Busy ? TX_SEND : IDLE;
        end
      end
      TX_SEND: begin
        if (!TX_Busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wr_en_nx  = 1'b0;
    rd_en_nx  = 1'b0;
    tx_vld_nx = 1'b0;
    err_nx    = 1'b0;
    addr_nx   = Address;
    wdata_nx  = WrData;
    txd_nx    = TX_P_DATA;
    unique case (state)
      IDLE: begin
        err_nx = RX_D_VLD
              && (RX_P_DATA != WR_CMD)
              && (RX_P_DATA != RD_CMD);
      end
      WR_ADDR: begin
        if (RX_D_VLD) addr_nx = RX_P_DATA[ADDR-1:0];
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wdata_nx = RX_P_DATA;
          wr_en_nx = 1'b1;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_nx  = RX_P_DATA[ADDR-1:0];
          rd_en_nx = 1'b1;
        end
      end
      RD_WAIT: begin
        err_nx = RX_D_VLD || tmo_hit;
        if (!tmo_hit && RdData_VLD) begin
          txd_nx    = RdData;
          tx_vld_nx = !TX_Busy;
        end
      end
      TX_SEND: begin
        err_nx    = RX_D_VLD;
        tx_vld_nx = !TX_Busy;
      end
      default: begin
        err_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      CMD_ERR   <= 1'b0;
    end else begin
      WrEn      <= wr_en_nx;
      RdEn      <= rd_en_nx;
      Address   <= addr_nx;
      WrData    <= wdata_nx;
      TX_P_DATA <= txd_nx;
      TX_D_VLD  <= tx_vld_nx;
      CMD_ERR   <= err_nx;
    end
  end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Directed bench for regfile_cmd_ctrl with a small register-file model.
// Build with RD_TIMEOUT_EN defined to exercise the read watchdog.
module tb_regfile_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic [7:0] RdData;
  logic       RdData_VLD;
  logic       TX_Busy;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       CMD_ERR;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int tx_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic mute = 1'b0;
  logic [7:0] mem [16];

  always #5 CLK = ~CLK;

  regfile_cmd_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_P_DATA  (RX_P_DATA),
    .RX_D_VLD   (RX_D_VLD),
    .RdData     (RdData),
    .RdData_VLD (RdData_VLD),
    .TX_Busy    (TX_Busy),
    .WrEn       (WrEn),
    .RdEn       (RdEn),
    .Address    (Address),
    .WrData     (WrData),
    .TX_P_DATA  (TX_P_DATA),
    .TX_D_VLD   (TX_D_VLD),
    .CMD_ERR    (CMD_ERR)
  );

  // Register file: one-cycle read latency, answers the cycle after RdEn
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      RdData_VLD <= 1'b0;
      RdData     <= 8'h00;
    end else begin
      RdData_VLD <= RdEn && !mute;
      if (RdEn) RdData <= mem[Address];
      if (WrEn) mem[Address] <= WrData;
    end
  end

  always @(negedge CLK) begin
    if (WrEn) wr_cnt++;
    if (RdEn) rd_cnt++;
    if (TX_D_VLD) tx_cnt++;
    if (CMD_ERR) err_cnt++;
    if (WrEn && RdEn) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Byte is sampled by the edge inside; returns 1 time unit after it
  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    step();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic clr_cnt();
    wr_cnt = 0;
    rd_cnt = 0;
    tx_cnt = 0;
    err_cnt = 0;
  endtask

  initial begin
    RST = 1'b1;
    RX_P_DATA = 8'h00;
    RX_D_VLD = 1'b0;
    TX_Busy = 1'b0;
    step();
    step();
    chk("rst_outs", {WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR}, 32'h0);
    RST = 1'b0;
    step();

    // Plain write
    clr_cnt();
    send(8'hAA);
    send(8'h05);
    send(8'h3C);
    chk("wr_en", WrEn, 1);
    chk("wr_addr", Address, 4'h5);
    chk("wr_data", WrData, 8'h3C);
    step();
    chk("wr_en_pulse", WrEn, 0);
    chk("wr_counts", {wr_cnt[7:0], rd_cnt[7:0], err_cnt[7:0]}, {8'd1, 8'd0, 8'd0});

    // Read with 3-cycle latency
    send(8'hAA);
    send(8'h02);
    send(8'h81);
    step();
    clr_cnt();
    send(8'hBB);
    send(8'h02);
    chk("rd_en", RdEn, 1);
    chk("rd_addr", Address, 4'h2);
    step();
    chk("rd_en_pulse", RdEn, 0);
    chk("tx_early", TX_D_VLD, 0);
    step();
    chk("tx_vld", TX_D_VLD, 1);
    chk("tx_data", TX_P_DATA, 8'h81);
    step();
    chk("tx_pulse", TX_D_VLD, 0);
    chk("rd_counts", {rd_cnt[7:0], tx_cnt[7:0], wr_cnt[7:0]}, {8'd1, 8'd1, 8'd0});

    // Read held off by TX_Busy, with a dropped byte meanwhile
    send(8'hAA);
    send(8'h09);
    send(8'h5A);
    step();
    clr_cnt();
    TX_Busy = 1'b1;
    send(8'hBB);
    send(8'h09);
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      chk("busy_hold_vld", TX_D_VLD, 0);
      chk("busy_hold_data", TX_P_DATA, 8'h5A);
      if (i == 3) begin
        send(8'h11);
        chk("busy_drop_err", CMD_ERR, 1);
      end else begin
        step();
      end
    end
    TX_Busy = 1'b0;
    step();
    chk("busy_tx_vld", TX_D_VLD, 1);
    chk("busy_tx_data", TX_P_DATA, 8'h5A);
    step();
    chk("busy_counts", {tx_cnt[7:0], err_cnt[7:0]}, {8'd1, 8'd1});

    // Illegal byte then a normal write
    clr_cnt();
    send(8'h55);
    chk("bad_err", CMD_ERR, 1);
    chk("bad_strobes", {WrEn, RdEn}, 0);
    send(8'hAA);
    chk("bad_err_pulse", CMD_ERR, 0);
    send(8'h01);
    send(8'hFF);
    chk("post_bad_wr", {WrEn, Address, WrData}, {1'b1, 4'h1, 8'hFF});
    step();
    chk("bad_counts", {err_cnt[7:0], wr_cnt[7:0]}, {8'd1, 8'd1});

    // Command codes as operands, upper address bits ignored
    send(8'hAA);
    send(8'hF3);
    send(8'hBB);
    chk("opnd_wr", {WrEn, Address, WrData}, {1'b1, 4'h3, 8'hBB});
    step();

    // Reset mid-frame, then read back an earlier write
    send(8'hAA);
    send(8'h07);
    send(8'hC3);
    step();
    clr_cnt();
    send(8'hAA);
    send(8'h07);
    RST = 1'b1;
    #1;
    chk("midrst_outs", {WrEn, RdEn, Address, WrData, TX_D_VLD, CMD_ERR}, 0);
    step();
    RST = 1'b0;
    step();
    send(8'hBB);
    send(8'h07);
    step();
    step();
    chk("midrst_rd", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'hC3});
    step();
    chk("midrst_counts", {wr_cnt[7:0], rd_cnt[7:0], tx_cnt[7:0]}, {8'd0, 8'd1, 8'd1});

    // Register file never answers
    clr_cnt();
    mute = 1'b1;
    send(8'hBB);
    send(8'h04);
`ifdef RD_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) chk("tmo_early", CMD_ERR, 0);
    end
    chk("tmo_err", CMD_ERR, 1);
    mute = 1'b0;
    step();
    chk("tmo_counts", {err_cnt[7:0], tx_cnt[7:0]}, {8'd1, 8'd0});
    send(8'hAA);
    send(8'h0A);
    send(8'h77);
    chk("tmo_post_wr", {WrEn, Address, WrData}, {1'b1, 4'hA, 8'h77});
    step();
`else
    for (int i = 0; i < 20; i++) step();
    chk("stall_counts", {err_cnt[7:0], tx_cnt[7:0]}, {8'd0, 8'd0});
    send(8'h22);
    chk("stall_drop_err", CMD_ERR, 1);
    mute = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
    send(8'hAA);
    send(8'h0A);
    send(8'h77);
    chk("stall_post_wr", {WrEn, Address, WrData}, {1'b1, 4'hA, 8'h77});
    step();
`endif

    chk("wr_rd_overlap", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
